// File: rtl/vram_arb_pkg.sv
// VRAM arbiter shared types: owner tags, CPU FSM states, defaults.
// Imported by the arbiter top and its tag/data-return pipeline.
package vram_arb_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      OWN_DISP = 1'b0,
      OWN_CPU  = 1'b1
   } owner_e;

   typedef enum logic [2:0] {
      IDLE,
      PEND,
      RD_WAIT,
      RD_DONE,
      WR_DONE
   } cpu_state_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } tag_t;

endpackage

// File: rtl/vram_arb_tag_pipe.sv
// Two-stage read tag pipeline; steers VRAM read data to display or CPU.
// Ports: issue_valid/issue_cpu (read issued this edge), ram_rdata in;
//        disp_valid/disp_data and cpu_valid/cpu_rdata registered out.
module vram_arb_tag_pipe
   import vram_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              pixel_clock,
   input  logic              reset_n,
   input  logic              issue_valid,
   input  logic              issue_cpu,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   output logic              cpu_valid,
   output logic [DATA_W-1:0] cpu_rdata
);

   tag_t stage0;
   tag_t stage1;
   logic ret_disp;
   logic ret_cpu;

   // stage1 tracks the RAM access edge; its data shows up on
   // ram_rdata during the following cycle.
   assign ret_disp = stage1.valid & (stage1.owner == OWN_DISP);
   assign ret_cpu  = stage1.valid & (stage1.owner == OWN_CPU);

   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         stage0     <= '0;
         stage1     <= '0;
         disp_valid <= 1'b0;
         disp_data  <= '0;
         cpu_valid  <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         stage0.valid <= issue_valid;
         stage0.owner <= issue_cpu ? OWN_CPU : OWN_DISP;
         stage1       <= stage0;
         disp_valid   <= ret_disp;
         cpu_valid    <= ret_cpu;
         if (ret_disp) begin
            disp_data <= ram_rdata;
         end
         if (ret_cpu) begin
            cpu_rdata <= ram_rdata;
         end
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads first, CPU takes free cycles.
// Ports: disp_* read path, cpu_* Z80 req/ack/wait, ram_* VRAM macro side.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_STALL = 15
) (
   input  logic              pixel_clock,
   input  logic              reset_n,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_wait,
   output logic              stall_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CNT_W = $clog2(MAX_STALL + 2);
   localparam logic [CNT_W-1:0] CNT_SAT =
      CNT_W'(MAX_STALL + 1);

   cpu_state_e       state;
   cpu_state_e       state_nx;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] stall_cnt_nx;
   logic             cpu_try;
   logic             cpu_issue;
   logic             disp_issue;
   logic             rd_issue;
   logic             wr_ack;
   logic             cpu_rvalid;

   // A fresh request competes on the very edge it is first seen, so
   // an uncontended access issues without a dead PEND cycle.
   assign cpu_try    = cpu_req &
                       ((state == IDLE) | (state == PEND));
   assign disp_issue = disp_req;
   assign cpu_issue  = cpu_try & ~disp_req;
   assign rd_issue   = disp_issue | (cpu_issue & ~cpu_we);

   always_comb begin
      state_nx     = state;
      stall_cnt_nx = stall_cnt;
      unique case (state)
         IDLE, PEND: begin
            if (!cpu_req) begin
               state_nx     = IDLE;
               stall_cnt_nx = '0;
            end else if (disp_req) begin
               state_nx = PEND;
               // Every lost edge counts, the first one included.
               if (state == IDLE) begin
                  stall_cnt_nx = CNT_W'(1);
               end else if (stall_cnt != CNT_SAT) begin
                  stall_cnt_nx = stall_cnt + 1'b1;
               end
            end else begin
               state_nx     = cpu_we ? WR_DONE : RD_WAIT;
               stall_cnt_nx = '0;
            end
         end
         RD_WAIT: state_nx = RD_DONE;
         RD_DONE: state_nx = IDLE;
         WR_DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         stall_cnt <= '0;
         stall_err <= 1'b0;
         wr_ack    <= 1'b0;
      end else begin
         state     <= state_nx;
         stall_cnt <= stall_cnt_nx;
         stall_err <= stall_err | (stall_cnt_nx == CNT_SAT);
         wr_ack    <= (state == WR_DONE);
      end
   end

   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_en <= disp_issue | cpu_issue;
         ram_we <= cpu_issue & cpu_we;
         if (disp_issue) begin
            ram_addr <= disp_addr;
         end else if (cpu_issue) begin
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
         end
      end
   end

   vram_arb_tag_pipe #(
      .DATA_W(DATA_W)
   ) u_tag_pipe (
      .pixel_clock(pixel_clock),
      .reset_n    (reset_n),
      .issue_valid(rd_issue),
      .issue_cpu  (~disp_issue),
      .ram_rdata  (ram_rdata),
      .disp_valid (disp_valid),
      .disp_data  (disp_data),
      .cpu_valid  (cpu_rvalid),
      .cpu_rdata  (cpu_rdata)
   );

   // Writes ack from the FSM; reads ack when their tagged data returns.
   assign cpu_ack  = wr_ack | cpu_rvalid;
   assign cpu_wait = cpu_req & ~cpu_ack;

endmodule
